spot_occupancy_tracker: RTL

//   Front end of the occupancy path. Takes the 8 raw per-spot car sensors, synchronises and

---
 rtl/spot_occupancy_tracker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spot_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// spot_occupancy_tracker
//
// Purpose:
//   Front end of the parking-lot occupancy path. Each of the 8 raw spot sensors
//   is brought into the clk domain through a 2-flop synchroniser. It is then
//   debounced by a per-spot counter before it is allowed to change the clean
//   occupancy bitmap new_capacity. Every bitmap change is flagged with a
//   one-cycle update pulse and a mask of the bits that flipped. Registered
//   full/empty status is derived from the same next-state bitmap.
//
// Ports:
//   clk           in   1  single clock, rising edge
//   rst_n         in   1  asynchronous, active-low reset
//   sensor_raw    in   8  raw spot sensors (1 = car present), async to clk
//   freeze        in   1  1 = hold bitmap and all debounce counters
//   new_capacity  out  8  debounced occupancy bitmap (1 = occupied)
//   update_valid  out  1  one-cycle pulse when new_capacity takes a new value
//   changed_mask  out  8  bits of new_capacity that flipped at that update
//   lot_full      out  1  new_capacity == 8'hFF
//   lot_empty     out  1  new_capacity == 8'h00
//
// Update pulse semantics: update_valid is a valid-only strobe with no ready.
// It is high for exactly the one cycle after the edge where new_capacity
// changed. changed_mask is meaningful only while update_valid is high and is
// zero otherwise. The consumer must sample the strobe on that cycle; it is
// never held or repeated.
// -----------------------------------------------------------------------------
module spot_occupancy_tracker #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sensor_raw,
  input  logic       freeze,
  output logic [7:0] new_capacity,
  output logic       update_valid,
  output logic [7:0] changed_mask,
  output logic       lot_full,
  output logic       lot_empty
);

  // Terminal count: a spot flips on the edge after it has already disagreed
  // for DEBOUNCE_CYCLES-1 consecutive synchronised samples.
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]            r_sync1;
  logic [7:0]            r_sync_s;
  logic [7:0][CNT_W-1:0] r_cnt;
  logic [7:0]            r_cap;
  logic                  r_valid;
  logic [7:0]            r_mask;
  logic                  r_full;
  logic                  r_empty;

  logic [7:0]            w_cap_next;
  logic [7:0][CNT_W-1:0] w_cnt_next;
  logic [7:0]            w_flip;

  // Per-spot debounce: any agreeing sample clears the count. The count
  // saturates at LP_CNT_MAX, where the bitmap bit takes the synchronised value
  // and the count restarts from zero.
  always_comb begin
    w_cap_next = r_cap;
    w_cnt_next = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_sync_s[i] != r_cap[i]) begin
        if (r_cnt[i] < LP_CNT_MAX) begin
          w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
        end else begin
          w_cap_next[i] = r_sync_s[i];
        end
      end
    end
  end

  assign w_flip = w_cap_next ^ r_cap;

  // Synchroniser runs regardless of freeze, so the first unfrozen edge sees
  // current sensor data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync_s <= '0;
    end else begin
      r_sync1  <= sensor_raw;
      r_sync_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_cap   <= '0;
      r_valid <= 1'b0;
      r_mask  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (freeze) begin
      // Counters, bitmap and status hold. A count that would have completed
      // on this edge completes on the first unfrozen edge, provided the spot
      // still disagrees then.
      r_valid <= 1'b0;
      r_mask  <= '0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_cap   <= w_cap_next;
      r_valid <= |w_flip;
      r_mask  <= w_flip;
      r_full  <= &w_cap_next;
      r_empty <= ~|w_cap_next;
    end
  end

  assign new_capacity = r_cap;
  assign update_valid = r_valid;
  assign changed_mask = r_mask;
  assign lot_full     = r_full;
  assign lot_empty    = r_empty;

endmodule
